// File: rtl/dmi_arbiter.sv
// Two-requester round-robin arbiter in front of a single DMI debug module port.
// Optional response timeout is compiled in with `define DMI_ARB_TIMEOUT_EN.
module dmi_arbiter #(
  parameter int DMI_ADDR_BITS  = 6,
  parameter int DMI_DATA_BITS  = 32,
  parameter int DMI_OP_BITS    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         m0_req_valid,
  output logic         m0_req_ready,
  input  logic [W-1:0] m0_req_data,
  output logic         m0_resp_valid,
  output logic [W-1:0] m0_resp_data,
  input  logic         m1_req_valid,
  output logic         m1_req_ready,
  input  logic [W-1:0] m1_req_data,
  output logic         m1_resp_valid,
  output logic [W-1:0] m1_resp_data,
  output logic         dm_req_valid,
  input  logic         dm_req_ready,
  output logic [W-1:0] dm_req_data,
  input  logic         dm_resp_valid,
  input  logic [W-1:0] dm_resp_data,
  output logic         grant_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic [W-1:0]   req_data_q, req_data_d;
  logic [W-1:0]   resp_data_q, resp_data_d;
  logic           sel;

`ifdef DMI_ARB_TIMEOUT_EN
  // Timeout answer carries only the "busy" op code so the requester can retry.
  localparam logic [W-1:0] BUSY_RESP =
    {{(W-DMI_OP_BITS){1'b0}}, {DMI_OP_BITS{1'b1}}};
  localparam logic [15:0]  TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
`endif

  // On a tie the requester that did not own the last transaction wins.
  assign sel = (m0_req_valid && m1_req_valid) ? ~grant_q : m1_req_valid;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    req_data_d   = req_data_q;
    resp_data_d  = resp_data_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        m0_req_ready = m0_req_valid && !sel;
        m1_req_ready = m1_req_valid && sel;
        if (m0_req_valid || m1_req_valid) begin
          grant_d    = sel;
          req_data_d = sel ? m1_req_data : m0_req_data;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (dm_req_ready) begin
          state_d = WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      WAIT: begin
        if (dm_resp_valid) begin
          resp_data_d = dm_resp_data;
          state_d     = RESP;
        end
`ifdef DMI_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LIMIT) begin
          resp_data_d = BUSY_RESP;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      req_data_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      req_data_q  <= req_data_d;
      resp_data_q <= resp_data_d;
    end
  end

`ifdef DMI_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign dm_req_valid  = (state_q == ISSUE);
  assign dm_req_data   = req_data_q;
  assign m0_resp_valid = (state_q == RESP) && !grant_q;
  assign m1_resp_valid = (state_q == RESP) && grant_q;
  assign m0_resp_data  = resp_data_q;
  assign m1_resp_data  = resp_data_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_dmi_arbiter.sv
// Scoreboard bench for dmi_arbiter: requests and DM responses are queued as
// they are driven and compared when the arbiter presents them.
module tb_dmi_arbiter;
  localparam int W = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m0_req_valid, m1_req_valid;
  logic         m0_req_ready, m1_req_ready;
  logic [W-1:0] m0_req_data, m1_req_data;
  logic         m0_resp_valid, m1_resp_valid;
  logic [W-1:0] m0_resp_data, m1_resp_data;
  logic         dm_req_valid, dm_req_ready;
  logic [W-1:0] dm_req_data;
  logic         dm_resp_valid;
  logic [W-1:0] dm_resp_data;
  logic         grant_o, busy_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit           grant_exp_q[$];

  always #5 clk = ~clk;

  dmi_arbiter #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_data(m0_req_data),
    .m0_resp_valid(m0_resp_valid), .m0_resp_data(m0_resp_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_data(m1_req_data),
    .m1_resp_valid(m1_resp_valid), .m1_resp_data(m1_resp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_data(dm_req_data),
    .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  function automatic logic [W-1:0] mk(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op);
    return {a, d, op};
  endfunction

  // Advance to just after the next falling edge: inputs change and outputs are sampled here.
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Waits (bounded) for the DM request, accepts it, then answers one cycle into WAIT.
  // Returns positioned in the RESP cycle.
  task automatic run_dm(input logic [W-1:0] rsp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dm_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dm_req_timeout got dm_req_valid=0 for 20 cycles need 1");
      return;
    end
    dm_req_ready = 1'b1;
    tick();
    dm_resp_valid = 1'b1;
    dm_resp_data  = rsp;
    tick();
    dm_resp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    m0_req_valid = 0; m1_req_valid = 0; m0_req_data = '0; m1_req_data = '0;
    dm_req_ready = 0; dm_resp_valid = 0; dm_resp_data = '0;
    tick(); tick();
    checks++;
    if (busy_o !== 1'b0 || grant_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got busy=%b grant=%b need busy=0 grant=1", busy_o, grant_o);
    end
    checks++;
    if (dm_req_valid !== 1'b0 || m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids got dm=%b r0=%b r1=%b need 0 0 0", dm_req_valid, m0_resp_valid, m1_resp_valid);
    end
    checks++;
    if (m0_resp_data !== '0 || dm_req_data !== '0) begin
      errors++;
      $display("FAIL reset_data got resp=%h req=%h need 0 0", m0_resp_data, dm_req_data);
    end
    rst_n = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_single;
    logic [W-1:0] w, r, e;
    w = mk(6'h0A, 32'h12345678, 2'd1);
    r = mk(6'h0A, 32'hCAFEF00D, 2'd0);
    m0_req_valid = 1'b1; m0_req_data = w; dm_req_ready = 1'b1;
    #1;
    checks++;
    if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready got r0=%b r1=%b need 1 0", m0_req_ready, m1_req_ready);
    end
    exp_q.push_back(w);
    tick();
    m0_req_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (dm_req_valid !== 1'b1 || dm_req_data !== e || grant_o !== 1'b0 || m0_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_issue got v=%b d=%h g=%b rdy=%b need 1 %h 0 0", dm_req_valid, dm_req_data, grant_o, m0_req_ready, e);
    end
    exp_q.push_back(r);
    run_dm(r);
    e = exp_q.pop_front();
    checks++;
    if (m0_resp_valid !== 1'b1 || m1_resp_valid !== 1'b0 || m0_resp_data !== e || m1_resp_data !== e) begin
      errors++;
      $display("FAIL single_resp got v0=%b v1=%b d0=%h d1=%h need 1 0 %h %h", m0_resp_valid, m1_resp_valid, m0_resp_data, m1_resp_data, e, e);
    end
    // A DM strobe outside WAIT must leave the captured word alone.
    dm_resp_valid = 1'b1; dm_resp_data = mk(6'h3F, 32'hDEADBEEF, 2'd2);
    tick();
    checks++;
    if (m0_resp_valid !== 1'b0 || busy_o !== 1'b0 || m0_resp_data !== e) begin
      errors++;
      $display("FAIL single_after got v0=%b busy=%b d0=%h need 0 0 %h", m0_resp_valid, busy_o, m0_resp_data, e);
    end
    tick();
    dm_resp_valid = 1'b0;
    checks++;
    if (m0_resp_data !== e || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_resp got d0=%h busy=%b need %h 0", m0_resp_data, busy_o, e);
    end
    $display("txn single m0 req=%h resp=%h", w, m0_resp_data);
  endtask

  task automatic test_round_robin;
    logic [W-1:0] a0, a1, e, rw;
    bit g;
    a0 = mk(6'h01, 32'h00000A0A, 2'd1);
    a1 = mk(6'h02, 32'h00000B0B, 2'd2);
    rst_n = 1'b0; dm_req_ready = 1'b1;
    m0_req_valid = 1'b1; m0_req_data = a0;
    m1_req_valid = 1'b1; m1_req_data = a1;
    tick();
    rst_n = 1'b1;
    grant_exp_q.push_back(1'b0); grant_exp_q.push_back(1'b1);
    grant_exp_q.push_back(1'b0); grant_exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      g = grant_exp_q.pop_front();
      checks++;
      if (m0_req_ready !== !g || m1_req_ready !== g) begin
        errors++;
        $display("FAIL rr_ready%0d got r0=%b r1=%b need %b %b", i, m0_req_ready, m1_req_ready, !g, g);
      end
      exp_q.push_back(g ? a1 : a0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (grant_o !== g || dm_req_data !== e) begin
        errors++;
        $display("FAIL rr_grant%0d got g=%b d=%h need %b %h", i, grant_o, dm_req_data, g, e);
      end
      rw = mk(6'(i), 32'h5000_0000 + 32'(i), 2'd0);
      run_dm(rw);
      checks++;
      if (m0_resp_valid !== !g || m1_resp_valid !== g || m0_resp_data !== rw) begin
        errors++;
        $display("FAIL rr_resp%0d got v0=%b v1=%b d=%h need %b %b %h", i, m0_resp_valid, m1_resp_valid, m0_resp_data, !g, g, rw);
      end
      $display("txn rr %0d owner=m%0d resp=%h", i, grant_o, m0_resp_data);
      tick();
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall;
    logic [W-1:0] s0, s1, rsp;
    s0 = mk(6'h11, 32'h01020304, 2'd1);
    s1 = mk(6'h22, 32'h05060708, 2'd2);
    rsp = mk(6'h11, 32'hA5A5A5A5, 2'd0);
    dm_req_ready = 1'b0;
    m0_req_valid = 1'b1; m0_req_data = s0;
    #1;
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b1; m1_req_data = s1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dm_req_valid !== 1'b1 || dm_req_data !== s0 || m1_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d got v=%b d=%h r1=%b need 1 %h 0", i, dm_req_valid, dm_req_data, m1_req_ready, s0);
      end
      tick();
    end
    run_dm(rsp);
    checks++;
    if (m0_resp_valid !== 1'b1 || m0_resp_data !== rsp) begin
      errors++;
      $display("FAIL stall_resp got v0=%b d=%h need 1 %h", m0_resp_valid, m0_resp_data, rsp);
    end
    $display("txn stall m0 req=%h resp=%h", s0, m0_resp_data);
    tick();
    checks++;
    if (m1_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_m1_ready got %b need 1", m1_req_ready);
    end
    tick();
    m1_req_valid = 1'b0;
    checks++;
    if (dm_req_data !== s1 || grant_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_m1_issue got d=%h g=%b need %h 1", dm_req_data, grant_o, s1);
    end
    run_dm(rsp ^ 40'h1);
    checks++;
    if (m1_resp_valid !== 1'b1 || m0_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_m1_resp got v1=%b v0=%b need 1 0", m1_resp_valid, m0_resp_valid);
    end
    $display("txn stall m1 req=%h resp=%h", s1, m1_resp_data);
    tick();
  endtask

`ifdef DMI_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [W-1:0] busy_word;
    busy_word = {38'd0, 2'b11};
    dm_req_ready = 1'b1;
    m0_req_valid = 1'b1; m0_req_data = mk(6'h33, 32'h0BADF00D, 2'd1);
    #1;
    tick();
    m0_req_valid = 1'b0;
    tick();
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (m0_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early%0d got v0=%b need 0", k, m0_resp_valid);
      end
      tick();
    end
    checks++;
    if (m0_resp_valid !== 1'b1 || m0_resp_data !== busy_word) begin
      errors++;
      $display("FAIL timeout_resp got v0=%b d=%h need 1 %h", m0_resp_valid, m0_resp_data, busy_word);
    end
    $display("txn timeout m0 resp=%h", m0_resp_data);
    tick();
    dm_resp_valid = 1'b1; dm_resp_data = mk(6'h3F, 32'hFFFFFFFF, 2'd0);
    tick();
    dm_resp_valid = 1'b0;
    checks++;
    if (m0_resp_data !== busy_word || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late got d=%h busy=%b need %h 0", m0_resp_data, busy_o, busy_word);
    end
  endtask
`endif

  task automatic test_reset_mid;
    dm_req_ready = 1'b1;
    m0_req_valid = 1'b1; m0_req_data = mk(6'h2A, 32'h77777777, 2'd1);
    #1;
    tick();
    m0_req_valid = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b1 || dm_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait got busy=%b v=%b need 1 0", busy_o, dm_req_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy_o !== 1'b0 || grant_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got busy=%b g=%b need 0 1", busy_o, grant_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_noresp%0d got v0=%b v1=%b need 0 0", i, m0_resp_valid, m1_resp_valid);
      end
      tick();
    end
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    #1;
    checks++;
    if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_tie got r0=%b r1=%b need 1 0", m0_req_ready, m1_req_ready);
    end
    $display("txn reset during WAIT, next tie to m0");
    tick();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    run_dm('0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
`ifdef DMI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish need finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 SHALL have parameters: DMI_ADDR_BITS, 6, DMI address width; DMI_DATA_BITS, 32, DMI data width; DMI_OP_BITS, 2, DMI op width; TIMEOUT_CYCLES, 255, response timeout in clk cycles (1..65535).
REQ-002 SHALL define W = DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS (default 40); packing {addr, data, op}, op in LSBs.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset rst_n, synchronous, active-low.
- m0_req_valid / m1_req_valid  in  1  requester 0/1 has a request.
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle.
- m0_req_data / m1_req_data  in  W  request word.
- m0_resp_valid / m1_resp_valid  out  1  one-cycle response strobe.
- m0_resp_data / m1_resp_data  out  W  response word, shared register driven to both.
- dm_req_valid  out  1  request to DM.
- dm_req_ready  in  1  DM accepts request.
- dm_req_data  out  W  request word to DM.
- dm_resp_valid  in  1  DM response strobe.
- dm_resp_data  in  W  DM response word.
- grant_o  out  1  owner of current/last transaction (0 = m0, 1 = m1).
- busy_o  out  1  high whenever state != IDLE.

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one outstanding transaction maximum.
REQ-005 IDLE: mX_req_ready SHALL be combinational, high only for the selected requester; transfer on valid&ready; data latched; grant_o updated; next state ISSUE.
REQ-006 Selection SHALL be round-robin: single valid requester wins; both valid -> requester != grant_o wins.
REQ-007 mX_req_ready SHALL be 0 in all states other than IDLE.
REQ-008 ISSUE: dm_req_valid = 1, dm_req_data = latched word, both stable until dm_req_ready; on dm_req_valid&dm_req_ready -> WAIT.
REQ-009 WAIT: on dm_resp_valid, dm_resp_data SHALL be registered into mX_resp_data; next state RESP.
REQ-010 RESP: resp_valid of the granted requester only SHALL be 1 for exactly one cycle (no backpressure); next state IDLE.
REQ-011 dm_resp_valid outside WAIT SHALL be ignored (no state or data change).
REQ-012 Latency: accept at cycle N -> dm_req_valid at N+1; dm_resp_valid at cycle M in WAIT -> mX_resp_valid at M+1; earliest next accept at M+2.
REQ-013 mX_resp_data SHALL hold its value until the next response capture.

Reset
REQ-014 When rst_n = 0 at a clk edge: state IDLE, grant_o = 1 (m0 wins first tie), dm_req_valid = 0, mX_resp_valid = 0, mX_resp_data = 0, dm_req_data = 0, timeout counter = 0.
REQ-015 Reset mid-transaction SHALL abandon it; no resp_valid issued for it.

Configuration
REQ-016 Macro DMI_ARB_TIMEOUT_EN defined: 16-bit counter cleared on entry to WAIT, increments each WAIT cycle without dm_resp_valid; when it reaches TIMEOUT_CYCLES, resp word = {zeros, op = all ones (busy)}, next state RESP; dm_resp_valid in the same cycle as expiry takes precedence.
REQ-017 Macro undefined: no counter logic; WAIT held until dm_resp_valid.

Verification
REQ-018 m0 alone, data 0x0A_12345678_1 (addr 0x0A, data 0x12345678, op 1), dm_req_ready = 1, DM response 0x0A_CAFEF00D_0 two cycles later -> m0_resp_valid one cycle with that word; m1_resp_valid stays 0.
REQ-019 m0 and m1 both valid continuously after reset -> grants alternate m0, m1, m0, m1; grant_o follows.
REQ-020 dm_req_ready held low 5 cycles -> dm_req_valid and dm_req_data stable throughout; m1 request meanwhile not accepted.
REQ-021 DMI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 10, DM silent -> resp word op = 2'b11, addr/data 0, 11 cycles after WAIT entry; a later dm_resp_valid is ignored.
REQ-022 rst_n low for 1 cycle during WAIT -> busy_o = 0, no resp_valid; next tie grants m0.
